// File: rtl/or_sweep_pkg.sv
// Shared types and default constants for the OR-gate sweep checker.
package or_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCheck,
        StDone
    } or_sweep_state_e;

    localparam int unsigned OR_SWEEP_WIDTH  = 10;
    localparam int unsigned OR_SWEEP_SETTLE = 1;

endpackage

// File: rtl/or_golden.sv
// Golden model for the OR gate: reduction-OR of the applied vector.
// Kept as its own module so another ready-made gate's model can be dropped in.
module or_golden #(
    parameter int unsigned WIDTH = 10
) (
    input  logic [WIDTH-1:0] vec,
    output logic             expected
);

    // Pure combinational reference value.
    always_comb begin
        expected = |vec;
    end

endmodule

// File: rtl/or_sweep_checker.sv
// Exhaustive sweep-and-check engine: walks every WIDTH-bit vector into the
// OR gate, samples its output after SETTLE cycles and logs mismatches.
module or_sweep_checker
    import or_sweep_pkg::*;
#(
    parameter int unsigned WIDTH  = OR_SWEEP_WIDTH,
    parameter int unsigned SETTLE = OR_SWEEP_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] vec,
    input  logic             dut_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_valid,
    output logic [WIDTH-1:0] err_vec,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_err_vec,
    output logic             first_err_valid
);

    localparam logic [WIDTH-1:0] VecMax     = '1;
    localparam logic [3:0]       SettleInit = 4'(SETTLE);

    or_sweep_state_e state_q;
    logic [3:0]      settle_q;
    logic            expected;
    logic            mismatch;
    logic [WIDTH:0]  err_count_inc;

    or_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .vec      (vec),
        .expected (expected)
    );

    // Compare the sampled DUT output and precompute the bumped error count.
    always_comb begin
        mismatch      = (dut_o != expected);
        err_count_inc = err_count + {{WIDTH{1'b0}}, mismatch};
    end

    // Sweep FSM with vector/settle counters and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            settle_q        <= '0;
            vec             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_valid       <= 1'b0;
            err_vec         <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (abort) begin
                        // Abort wins over start; results are kept for inspection.
                        state_q <= StIdle;
                        vec     <= '0;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end else if (start) begin
                        state_q         <= StWait;
                        vec             <= '0;
                        settle_q        <= SettleInit;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                StWait: begin
                    if (abort) begin
                        state_q <= StIdle;
                        vec     <= '0;
                        busy    <= 1'b0;
                    end else if (settle_q == 4'd1) begin
                        state_q <= StCheck;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                StCheck: begin
                    if (abort) begin
                        // No check is performed in the abort cycle.
                        state_q <= StIdle;
                        vec     <= '0;
                        busy    <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_valid <= 1'b1;
                            err_vec   <= vec;
                            err_count <= err_count_inc;
                            if (!first_err_valid) begin
                                first_err_vec   <= vec;
                                first_err_valid <= 1'b1;
                            end
                        end
                        if (vec == VecMax) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_count_inc == '0);
                        end else begin
                            state_q  <= StWait;
                            vec      <= vec + 1'b1;
                            settle_q <= SettleInit;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or_sweep_checker.sv
// Directed bench for or_sweep_checker: default instance plus a SETTLE=3 instance.
`timescale 1ns/1ps
module tb_or_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fault_mode;

    // Default instance (WIDTH=10, SETTLE=1)
    logic        start, abort, dut_o;
    logic [9:0]  vec, err_vec, first_err_vec;
    logic [10:0] err_count;
    logic        busy, done, pass, err_valid, first_err_valid;

    // SETTLE=3 instance
    logic        start3, abort3, dut_o3;
    logic [9:0]  vec3, err_vec3, first_err_vec3;
    logic [10:0] err_count3;
    logic        busy3, done3, pass3, err_valid3, first_err_valid3;

    logic [9:0]  log_q[$];
    logic [9:0]  log3_q[$];

    always #5 clk = ~clk;

    or_sweep_checker u_dut (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort), .vec (vec),
        .dut_o (dut_o), .busy (busy), .done (done), .pass (pass),
        .err_valid (err_valid), .err_vec (err_vec), .err_count (err_count),
        .first_err_vec (first_err_vec), .first_err_valid (first_err_valid)
    );

    or_sweep_checker #(.WIDTH (10), .SETTLE (3)) u_dut3 (
        .clk (clk), .rst_n (rst_n), .start (start3), .abort (abort3), .vec (vec3),
        .dut_o (dut_o3), .busy (busy3), .done (done3), .pass (pass3),
        .err_valid (err_valid3), .err_vec (err_vec3), .err_count (err_count3),
        .first_err_vec (first_err_vec3), .first_err_valid (first_err_valid3)
    );

    // Emulated OR gate with selectable faults.
    always_comb begin
        case (fault_mode)
            1:       dut_o = 1'b0;
            2:       dut_o = 1'b1;
            4:       dut_o = (|vec) ^ (vec == 10'd50);
            default: dut_o = |vec;
        endcase
        dut_o3 = (|vec3) ^ (vec3 == 10'h200);
    end

    // Log every error pulse.
    always @(negedge clk) begin
        if (rst_n && err_valid) log_q.push_back(err_vec);
        if (rst_n && err_valid3) log3_q.push_back(err_vec3);
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Start a sweep, wait for done (bounded); cycles = -1 on timeout.
    task automatic run_sweep(output int cycles);
        log_q.delete();
        pulse_start();
        cycles = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(posedge clk); #1;
            if (done) begin cycles = i; break; end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({vec, busy, done, pass, err_valid, err_vec, err_count, first_err_vec,
             first_err_valid} !== '0) begin
            n_bad++;
            $display("FAIL reset_vals: vec=%0d busy=%b done=%b pass=%b ev=%b evec=%0d cnt=%0d fv=%0d fvld=%b required all 0",
                     vec, busy, done, pass, err_valid, err_vec, err_count, first_err_vec,
                     first_err_valid);
        end
    endtask

    task automatic test_fault_free();
        int cyc;
        fault_mode = 0;
        run_sweep(cyc);
        n_cmp++; if (cyc !== 2048) begin n_bad++; $display("FAIL ff_latency: got %0d required 2048", cyc); end
        n_cmp++; if (err_count !== 11'd0) begin n_bad++; $display("FAIL ff_count: got %0d required 0", err_count); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL ff_pass: got %b required 1", pass); end
        n_cmp++; if (first_err_valid !== 1'b0) begin n_bad++; $display("FAIL ff_first_valid: got %b required 0", first_err_valid); end
        n_cmp++; if (log_q.size() != 0) begin n_bad++; $display("FAIL ff_pulses: got %0d required 0", log_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ff_busy_done: got %b required 0", busy); end
    endtask

    task automatic test_stuck0();
        int cyc;
        fault_mode = 1;
        run_sweep(cyc);
        n_cmp++; if (cyc !== 2048) begin n_bad++; $display("FAIL s0_latency: got %0d required 2048", cyc); end
        n_cmp++; if (err_count !== 11'd1023) begin n_bad++; $display("FAIL s0_count: got %0d required 1023", err_count); end
        n_cmp++; if (first_err_vec !== 10'd1 || first_err_valid !== 1'b1) begin n_bad++; $display("FAIL s0_first: got %0d/%b required 1/1", first_err_vec, first_err_valid); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL s0_pass: got %b required 0", pass); end
        n_cmp++;
        if (log_q.size() != 1023) begin
            n_bad++; $display("FAIL s0_pulses: got %0d required 1023", log_q.size());
        end else begin
            for (int k = 0; k < 1023; k++) begin
                n_cmp++;
                if (log_q[k] !== 10'(k + 1)) begin
                    n_bad++; $display("FAIL s0_err_vec[%0d]: got %0d required %0d", k, log_q[k], k + 1);
                end
            end
        end
    endtask

    task automatic test_stuck1();
        int cyc;
        fault_mode = 2;
        run_sweep(cyc);
        n_cmp++; if (err_count !== 11'd1) begin n_bad++; $display("FAIL s1_count: got %0d required 1", err_count); end
        n_cmp++; if (first_err_vec !== 10'd0 || first_err_valid !== 1'b1) begin n_bad++; $display("FAIL s1_first: got %0d/%b required 0/1", first_err_vec, first_err_valid); end
        n_cmp++; if (log_q.size() != 1) begin n_bad++; $display("FAIL s1_pulses: got %0d required 1", log_q.size()); end
        else begin
            n_cmp++; if (log_q[0] !== 10'd0) begin n_bad++; $display("FAIL s1_err_vec: got %0d required 0", log_q[0]); end
        end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL s1_pass: got %b required 0", pass); end
    endtask

    task automatic test_settle3();
        int cyc, t1, t2;
        cyc = -1; t1 = -1; t2 = -1;
        log3_q.delete();
        @(negedge clk); start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        for (int i = 1; i <= 6000; i++) begin
            @(posedge clk); #1;
            if (vec3 == 10'd1 && t1 < 0) t1 = i;
            if (vec3 == 10'd2 && t2 < 0) t2 = i;
            if (done3) begin cyc = i; break; end
        end
        @(negedge clk); #1;
        n_cmp++; if (cyc !== 4096) begin n_bad++; $display("FAIL s3_latency: got %0d required 4096", cyc); end
        n_cmp++; if (t1 !== 4) begin n_bad++; $display("FAIL s3_first_step: got %0d required 4", t1); end
        n_cmp++; if (t2 - t1 !== 4) begin n_bad++; $display("FAIL s3_period: got %0d required 4", t2 - t1); end
        n_cmp++; if (err_count3 !== 11'd1) begin n_bad++; $display("FAIL s3_count: got %0d required 1", err_count3); end
        n_cmp++; if (log3_q.size() != 1) begin n_bad++; $display("FAIL s3_pulses: got %0d required 1", log3_q.size()); end
        else begin
            n_cmp++; if (log3_q[0] !== 10'h200) begin n_bad++; $display("FAIL s3_err_vec: got %0h required 200", log3_q[0]); end
        end
        n_cmp++; if (first_err_vec3 !== 10'h200) begin n_bad++; $display("FAIL s3_first: got %0h required 200", first_err_vec3); end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        bit hit;
        fault_mode = 1;
        hit = 0;
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (vec == 10'd300) begin hit = 1; break; end
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL rst_reach_300: got vec %0d required 300", vec); end
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({vec, busy, done, pass, err_valid, err_vec, err_count, first_err_vec,
             first_err_valid} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_vals: vec=%0d busy=%b cnt=%0d fv=%0d fvld=%b evec=%0d required all 0",
                     vec, busy, err_count, first_err_vec, first_err_valid, err_vec);
        end
        @(negedge clk); rst_n = 1'b1;
        fault_mode = 0;
        run_sweep(cyc);
        n_cmp++; if (cyc !== 2048) begin n_bad++; $display("FAIL rst_restart_latency: got %0d required 2048", cyc); end
        n_cmp++; if (err_count !== 11'd0 || pass !== 1'b1) begin n_bad++; $display("FAIL rst_restart_clean: got cnt %0d pass %b required 0/1", err_count, pass); end
    endtask

    task automatic test_abort();
        bit hit;
        fault_mode = 4;
        hit = 0;
        log_q.delete();
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (vec == 10'd100) begin hit = 1; break; end
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL ab_reach_100: got vec %0d required 100", vec); end
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL ab_idle: got busy %b done %b required 0/0", busy, done); end
        n_cmp++; if (err_count !== 11'd1) begin n_bad++; $display("FAIL ab_count_kept: got %0d required 1", err_count); end
        n_cmp++; if (first_err_vec !== 10'd50 || first_err_valid !== 1'b1) begin n_bad++; $display("FAIL ab_first_kept: got %0d/%b required 50/1", first_err_vec, first_err_valid); end
        n_cmp++; if (log_q.size() != 1) begin n_bad++; $display("FAIL ab_pulses: got %0d required 1", log_q.size()); end
        n_cmp++; if (vec !== 10'd0) begin n_bad++; $display("FAIL ab_vec: got %0d required 0", vec); end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || vec !== 10'd0) begin n_bad++; $display("FAIL sa_stay_idle: got busy %b vec %0d required 0/0", busy, vec); end
        n_cmp++; if (err_count !== 11'd1) begin n_bad++; $display("FAIL sa_no_clear: got %0d required 1", err_count); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        fault_mode = 0;
        log_q.delete();
        pulse_start();
        cyc = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(posedge clk); #1;
            start = (i == 100);
            if (done) begin cyc = i; break; end
        end
        start = 1'b0;
        n_cmp++; if (cyc !== 2048) begin n_bad++; $display("FAIL busy_start_latency: got %0d required 2048", cyc); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL busy_start_pass: got %b required 1", pass); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        fault_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_fault_free();
        test_stuck0();
        test_stuck1();
        test_settle3();
        test_reset_mid_sweep();
        test_abort();
        test_start_abort_idle();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
